// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display controller.
package seg7_pkg;

    // Digit register interpretation, selected by the top bit of each digit register
    typedef enum logic {
        MODE_RAW = 1'b0,
        MODE_HEX = 1'b1
    } digitMode_e;

    localparam int MODE_BIT = 7;

    // Active-low pattern with every segment off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high segments g..a for hex digits 0..F
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment pattern (g..a).
module seg7_hex_decode (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    import seg7_pkg::*;

    // Straight table lookup of the nibble
    always_comb begin
        seg_o = HEX_SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped seven-segment controller: digit register file, blink timer,
// PWM brightness and a registered active-low segment output stage.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int ADDR_W     = 3,
    parameter int BLINK_DIV  = 25000000,
    parameter int PWM_W      = 4
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    Sel,
    input  logic                    Rd,
    input  logic [ADDR_W-1:0]       Addr,
    input  logic [7:0]              Data,
    output logic [7:0]              RdData,
    output logic [7*NUM_DIGITS-1:0] H
);
    import seg7_pkg::*;

    localparam int                PRE_W       = $clog2(BLINK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(BLINK_DIV - 1);
    localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(NUM_DIGITS);
    localparam logic [ADDR_W-1:0] BRIGHT_ADDR = ADDR_W'(NUM_DIGITS + 1);

    logic [7:0]              digit_q [NUM_DIGITS];
    logic [7:0]              digit_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blinkMask_q, blinkMask_d;
    logic [PWM_W-1:0]        bright_q, bright_d;
    logic [PWM_W-1:0]        pwmCnt_q, pwmCnt_d;
    logic [PRE_W-1:0]        prescaler_q, prescaler_d;
    logic                    blinkPhase_q, blinkPhase_d;
    logic [7:0]              rdData_q, rdData_d;
    logic [7*NUM_DIGITS-1:0] h_q, h_d;
    logic [6:0]              hexSeg [NUM_DIGITS];
    logic                    maskWrite;
    logic                    lit;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDecode
        seg7_hex_decode uDecode (
            .nibble_i (digit_q[g][3:0]),
            .seg_o    (hexSeg[g])
        );
    end

    // Register file writes and the read port; a read sees pre-write contents
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = digit_q[i];
            if (Sel && (Addr == ADDR_W'(i))) digit_d[i] = Data;
        end
        maskWrite   = Sel && (Addr == MASK_ADDR);
        blinkMask_d = maskWrite ? Data[NUM_DIGITS-1:0] : blinkMask_q;
        bright_d    = (Sel && (Addr == BRIGHT_ADDR)) ? Data[PWM_W-1:0] : bright_q;
        rdData_d    = rdData_q;
        if (Rd) begin
            rdData_d = 8'h00;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (Addr == ADDR_W'(i)) rdData_d = digit_q[i];
            end
            if (Addr == MASK_ADDR)   rdData_d = 8'(blinkMask_q);
            if (Addr == BRIGHT_ADDR) rdData_d = 8'(bright_q);
        end
    end

    // Blink prescaler and phase; a mask write restarts blinking in the visible phase
    always_comb begin
        prescaler_d  = prescaler_q + 1'b1;
        blinkPhase_d = blinkPhase_q;
        if (maskWrite) begin
            prescaler_d  = '0;
            blinkPhase_d = 1'b0;
        end else if (prescaler_q == PRE_LAST) begin
            prescaler_d  = '0;
            blinkPhase_d = ~blinkPhase_q;
        end
        pwmCnt_d = pwmCnt_q + 1'b1;
    end

    // Per-digit segment selection gated by brightness and blink
    always_comb begin
        logic [6:0] pattern;
        pattern = '0;
        h_d     = '1;
        lit     = (&bright_q) || (pwmCnt_q < bright_q);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pattern = (digitMode_e'(digit_q[i][MODE_BIT]) == MODE_HEX) ? hexSeg[i] : digit_q[i][6:0];
            h_d[7*i +: 7] = (lit && !(blinkMask_q[i] && blinkPhase_q)) ? ~pattern : SEG_BLANK;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 8'h00;
            blinkMask_q  <= '0;
            bright_q     <= '1;
            pwmCnt_q     <= '0;
            prescaler_q  <= '0;
            blinkPhase_q <= 1'b0;
            rdData_q     <= 8'h00;
            h_q          <= '1;
        end else begin
            digit_q      <= digit_d;
            blinkMask_q  <= blinkMask_d;
            bright_q     <= bright_d;
            pwmCnt_q     <= pwmCnt_d;
            prescaler_q  <= prescaler_d;
            blinkPhase_q <= blinkPhase_d;
            rdData_q     <= rdData_d;
            h_q          <= h_d;
        end
    end

    assign RdData = rdData_q;
    assign H      = h_q;

endmodule
